// File: rtl/multu_unit_pkg.sv
// ============================================================================
// Module      : multu_unit_pkg
// Description : Shared CPU package. Holds the default operand width, the
//               multiply-unit FSM state encoding, the ALU control codes and
//               a small helper used by the hazard/stall logic.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multu_unit_pkg;

  // Default operand width for the multiply unit; product is twice this.
  localparam int MULTU_WIDTH = 32;

  // Multiply unit sequencer states.
  typedef enum logic [1:0] {
    MU_IDLE = 2'd0,
    MU_RUN  = 2'd1,
    MU_DONE = 2'd2
  } multu_state_e;

  // ALU control codes shared with the EX stage.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA,
    ALU_LUI  = 4'hB
  } alu_ctrl_e;

  // True when an mfhi or mflo in EX wants the HI/LO pair.
  function automatic logic mf_request(input logic rd_hi, input logic rd_lo);
    return rd_hi | rd_lo;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multu_unit_if.sv
// ============================================================================
// Module      : multu_unit_if
// Description : Bus between the EX stage / hazard logic and the multiply
//               unit. The EX side uses the master modport, the unit uses
//               the slave modport.
// Signals     : start        - multu issue pulse
//               op_a, op_b   - multiplicand / multiplier, sampled with start
//               rd_hi, rd_lo - mfhi / mflo requests from EX
//               hi, lo       - HI/LO result registers
//               busy         - unit is iterating
//               done         - one-cycle pulse when HI/LO are updated
//               stall        - pipeline freeze request
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multu_unit_if
  import multu_unit_pkg::*;
#(
  parameter int WIDTH = MULTU_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             rd_hi;
  logic             rd_lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op_a, op_b, rd_hi, rd_lo,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op_a, op_b, rd_hi, rd_lo,
    output hi, lo, busy, done, stall
  );

endinterface

`default_nettype wire

// File: rtl/mul_datapath.sv
// ============================================================================
// Module      : mul_datapath
// Description : Unsigned shift-add multiply datapath. Holds the widened
//               multiplicand, the multiplier shift register and the
//               accumulator, and forms accumulator + partial product with a
//               ripple-carry adder (add32 structure widened to 2*WIDTH).
// Ports       : clk, rst     - clock, synchronous active-high reset
//               load         - capture operands, clear accumulator
//               step         - retire one partial product
//               op_a, op_b   - multiplicand / multiplier
//               sum          - accumulator plus current partial product
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] sum
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    carry;

  // Partial product for this cycle: multiplicand gated by multiplier LSB.
  assign addend   = mplier_q[0] ? mcand_q : '0;
  assign carry[0] = 1'b0;

  // Ripple-carry adder. The carry out of the top bit is never produced:
  // the running sum is bounded by the full product, which fits in PW bits.
  for (genvar i = 0; i < PW; i++) begin : g_add
    assign sum[i] = acc_q[i] ^ addend[i] ^ carry[i];
    if (i < PW - 1) begin : g_carry
      assign carry[i+1] = (acc_q[i] & addend[i]) |
                          (carry[i] & (acc_q[i] ^ addend[i]));
    end
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, op_a};
      mplier_d = op_b;
      acc_d    = '0;
    end else if (step) begin
      acc_d    = sum;
      mcand_d  = {mcand_q[PW-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multu_unit.sv
// ============================================================================
// Module      : multu_unit
// Description : Iterative unsigned multiplier (MIPS multu). One partial
//               product per cycle for exactly WIDTH cycles, then HI/LO are
//               written and done pulses for one cycle. Raises stall while an
//               mfhi/mflo would read a result that is not ready yet.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               bus  - multu_unit_if slave modport (start, op_a, op_b,
//                      rd_hi, rd_lo in; hi, lo, busy, done, stall out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multu_unit
  import multu_unit_pkg::*;
#(
  parameter int WIDTH = MULTU_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  multu_unit_if.slave    bus
);

  // One extra bit so the counter can hold WIDTH after the last step.
  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  multu_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;
  logic               load;
  logic               step;
  logic [2*WIDTH-1:0] sum;

  mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .op_a  (bus.op_a),
    .op_b  (bus.op_b),
    .sum   (sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      MU_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = MU_RUN;
        end
      end
      MU_RUN: begin
        // start is deliberately not looked at here: no restart mid-run.
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Final sum includes the last partial product; commit it directly.
          {hi_d, lo_d} = sum;
          state_d      = MU_DONE;
        end
      end
      MU_DONE: begin
        state_d = MU_IDLE;
      end
      default: begin
        state_d = MU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MU_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q == MU_RUN);
  assign bus.done = (state_q == MU_DONE);

  // An mfhi/mflo issued alongside a multu in IDLE must also wait.
  assign bus.stall = mf_request(bus.rd_hi, bus.rd_lo) &
                     ((state_q == MU_RUN) | ((state_q == MU_IDLE) & bus.start));

endmodule

`default_nettype wire

// File: tb/tb_multu_unit.sv
`default_nettype none

module tb_multu_unit;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  multu_unit_if #(.WIDTH(32)) bus ();

  multu_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one multu and follow it for 40 cycles. Cycle 1 is the first
  // negedge after the edge that samples start.
  task automatic run_op(input string tag,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ph, input logic [31:0] pl,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit rd_at_issue, input int rdlo_from,
                        input int start2_at);
    int lat, nbusy, ndone, st_err;
    bit held, at_done, exp_st;
    lat = 0; nbusy = 0; ndone = 0; st_err = 0; held = 1'b1; at_done = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.rd_hi = rd_at_issue;
    #1 chk({tag, "_issue_stall"}, {63'd0, bus.stall}, {63'd0, rd_at_issue});
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.rd_hi = 1'b0;
    bus.op_a = $urandom; bus.op_b = $urandom;
    @(negedge clk);
    for (int c = 1; c <= 40; c++) begin
      exp_st = (rdlo_from != 0) && (c >= rdlo_from) && (c <= 32);
      if (bus.stall !== exp_st) st_err++;
      if (bus.busy === 1'b1) begin
        nbusy++;
        if (bus.hi !== ph || bus.lo !== pl) held = 1'b0;
      end
      if (bus.done === 1'b1) begin
        ndone++;
        if (lat == 0) lat = c;
        if (bus.hi !== eh || bus.lo !== el) at_done = 1'b0;
      end
      bus.rd_lo = (rdlo_from != 0) && (c + 1 >= rdlo_from);
      bus.start = (start2_at != 0) && (c + 1 == start2_at);
      if (bus.start) begin
        bus.op_a = 32'd7; bus.op_b = 32'd7;
      end
      @(negedge clk);
    end
    bus.rd_lo = 1'b0;
    bus.start = 1'b0;
    chk({tag, "_latency"},    64'(lat),     64'd33);
    chk({tag, "_busy_cyc"},   64'(nbusy),   64'd32);
    chk({tag, "_done_cnt"},   64'(ndone),   64'd1);
    chk({tag, "_hold"},       64'(held),    64'd1);
    chk({tag, "_at_done"},    64'(at_done), 64'd1);
    chk({tag, "_stall_err"},  64'(st_err),  64'd0);
    chk({tag, "_hi"},         {32'd0, bus.hi}, {32'd0, eh});
    chk({tag, "_lo"},         {32'd0, bus.lo}, {32'd0, el});
  endtask

  initial begin : stim
    int ndone;
    rst = 1'b1;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.rd_hi = 1'b0; bus.rd_lo = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hi",    {32'd0, bus.hi}, 64'd0);
    chk("rst_lo",    {32'd0, bus.lo}, 64'd0);
    chk("rst_busy",  {63'd0, bus.busy},  64'd0);
    chk("rst_done",  {63'd0, bus.done},  64'd0);
    chk("rst_stall", {63'd0, bus.stall}, 64'd0);
    rst = 1'b0;

    // 3*5 with mflo held from cycle 5.
    run_op("mul3x5", 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 32'h0000000F, 1'b0, 5, 0);
    // Zero operand, previous result held; a second start at cycle 10 ignored.
    run_op("zero", 32'd0, 32'h12345678, 32'd0, 32'h0000000F, 32'd0, 32'd0, 1'b0, 0, 10);
    // Largest operands; mfhi together with the issuing start.
    run_op("ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,
           32'hFFFFFFFE, 32'h00000001, 1'b1, 0, 0);
    // Product crossing the HI/LO boundary.
    run_op("carry", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h00000001,
           32'h00000001, 32'hFFFFFFFE, 1'b0, 0, 0);

    // Reset in the middle of a run.
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1; bus.rd_hi = 1'b1;
    @(negedge clk);
    chk("midrst_busy",  {63'd0, bus.busy},  64'd0);
    chk("midrst_stall", {63'd0, bus.stall}, 64'd0);
    chk("midrst_done",  {63'd0, bus.done},  64'd0);
    chk("midrst_hi",    {32'd0, bus.hi},    64'd0);
    chk("midrst_lo",    {32'd0, bus.lo},    64'd0);
    rst = 1'b0; bus.rd_hi = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    chk("midrst_lo_after", {32'd0, bus.lo}, 64'd0);

    // Reset and start together: reset wins, nothing starts.
    rst = 1'b1; bus.start = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd5;
    @(negedge clk);
    chk("rststart_busy0", {63'd0, bus.busy}, 64'd0);
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("rststart_busy1", {63'd0, bus.busy}, 64'd0);
    chk("rststart_done",  {63'd0, bus.done}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
